regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wb0_valid  input  1  requester 0 (ALU writeback) has a write pending.
REQ-007 wb0_addr  input  ADDR_W  requester 0 destination register.
REQ-008 wb0_data  input  DATA_W  requester 0 write data.
REQ-009 wb0_ready  output  1  requester 0 write accepted this cycle.
REQ-010 wb1_valid, wb1_addr, wb1_data, wb1_ready: same as REQ-006..009, requester 1 (load writeback).
REQ-011 RegWrite  output  1  write enable to the register file.
REQ-012 write_reg  output  ADDR_W  register-file write address.
REQ-013 write_data  output  DATA_W  register-file write data.
REQ-014 busy  output  1  high while not in RUN state.

Function
REQ-015 SHALL implement states CLEAR and RUN; CLEAR exists only per REQ-031.
REQ-016 In RUN, grant: one valid requester -> grant it; both valid -> grant requester not granted last; none -> no grant.
REQ-017 wbN_ready SHALL be combinational: high only in RUN when requester N is granted; never both high.
REQ-018 Transfer occurs at the edge where wbN_valid && wbN_ready; the last-grant pointer updates only on a transfer.
REQ-019 Outputs RegWrite/write_reg/write_data SHALL be registered: transfer at edge N -> driven during cycle N+1, committed by the register file at edge N+1 (one-cycle latency).
REQ-020 No transfer at an edge -> RegWrite low next cycle; write_reg/write_data hold last value.
REQ-021 Transfer with address 0 SHALL be accepted (ready high) but produce RegWrite low (register 0 not writable).
REQ-022 Both requesters targeting the same address in one cycle: grant per REQ-016; loser writes on a later cycle, so loser's data is final.
REQ-023 A requester SHALL hold addr/data stable while valid && !ready; arbiter does not latch ungranted requests.
REQ-024 Sustained dual requests SHALL alternate 0,1,0,1 with one write per cycle (no bubbles).

Reset
REQ-025 On rst high at an edge: RegWrite=0, write_reg=0, write_data=0, last-grant=requester 1 (so requester 0 wins the first tie).
REQ-026 With REQ-031 enabled, reset SHALL enter CLEAR with sweep counter=0 and busy=1; otherwise RUN with busy=0.
REQ-027 Reset asserted mid-CLEAR SHALL restart the sweep from address 0; reset mid-transfer drops the pending output write (RegWrite low next cycle).
REQ-028 wbN_ready SHALL be low during any cycle rst is high.

Configuration
REQ-029 Macro REGFILE_WRITE_ARBITER_CLEAR_EN selects the post-reset clear sweep.
REQ-030 Defined: CLEAR state present; compiled out otherwise.
REQ-031 In CLEAR: each cycle drive RegWrite=1, write_reg=counter, write_data=0 (registered per REQ-019) for counter 0..2^ADDR_W-1; after last address, enter RUN; ready low throughout; 8 cycles at default.
REQ-032 Not defined: no CLEAR state, busy tied low, RUN immediately after reset.

Structure
REQ-033 Shared package regfile_pkg SHALL hold DATA_W/ADDR_W defaults, state encoding (CLEAR, RUN), and requester index constants.
REQ-034 Grant logic SHALL be one sub-module rr_arbiter2 (two-request round-robin, request/grant/last-grant ports); remainder in top.

Verification
REQ-035 Single: wb0 valid, addr=3, data=0xDEADBEEF, edge 0 -> wb0_ready=1; cycle 1 RegWrite=1, write_reg=3, write_data=0xDEADBEEF; register 3 reads 0xDEADBEEF.
REQ-036 Tie: both valid every cycle (wb0 addr=1 data=0x11, wb1 addr=2 data=0x22) -> grants 0,1,0,1; RegWrite high every cycle after first.
REQ-037 Same address: wb0 addr=5 data=0xA, wb1 addr=5 data=0xB, fresh reset -> register 5 = 0xA then 0xB; final 0xB.
REQ-038 Address 0: wb1 addr=0 data=0xFFFFFFFF -> wb1_ready=1, RegWrite stays 0; register 0 unchanged.
REQ-039 CLEAR (macro defined): preload registers with nonzero values, pulse rst -> busy=1 for 8 cycles, all registers read 0, ready low until busy=0; rst at clear cycle 4 restarts sweep at address 0.
REQ-040 Reset mid-transfer: transfer at edge N with rst high at edge N+1 -> RegWrite=0 after reset, tie-break returns to requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file write arbiter:
//   - default data/address widths
//   - arbiter state encoding (CLEAR sweep, RUN)
//   - requester index constants (ALU writeback = 0, load writeback = 1)
//   - small helper to turn a one-hot two-bit grant into a requester index
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 3;

    // CLEAR is only reachable when the clear-sweep build option is enabled.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    localparam logic REQ_ALU  = 1'b0;
    localparam logic REQ_LOAD = 1'b1;

    // Index of the granted requester; requester 1 only when its grant bit is set.
    function automatic logic grant_index(input logic [1:0] grant);
        logic idx;
        case (grant)
            2'b10:   idx = REQ_LOAD;
            2'b01:   idx = REQ_ALU;
            default: idx = REQ_ALU;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin grant logic (purely combinational).
//   req[1:0]    in  : request bits, bit N = requester N wants a grant
//   last_grant  in  : index of the requester that won the previous transfer
//   grant[1:0]  out : one-hot grant (or zero when nobody requests)
// On a tie the requester that did not win last time is granted, so a
// sustained dual request alternates 0,1,0,1.
// ---------------------------------------------------------------------------
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Round-robin grant decode.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
                if (last_grant == REQ_ALU) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates two writeback sources (ALU = requester 0, load = requester 1)
// onto the single write port of a register file.
//
// Ports:
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset
//   wb0_valid/addr/data     requester 0 write request
//   wb0_ready               requester 0 accepted this cycle (combinational)
//   wb1_valid/addr/data     requester 1 write request
//   wb1_ready               requester 1 accepted this cycle (combinational)
//   RegWrite                register-file write enable (registered)
//   write_reg               register-file write address (registered)
//   write_data              register-file write data (registered)
//   busy                    high while the post-reset clear sweep runs
//
// Build option: define REGFILE_WRITE_ARBITER_CLEAR_EN to zero every register
// after reset (one address per cycle) before accepting writebacks. Without
// it the arbiter runs immediately after reset and busy is tied low.
//
// A transfer at edge N appears on RegWrite/write_reg/write_data during cycle
// N+1. Writes to register 0 are accepted but suppressed (RegWrite stays low)
// because register 0 is hardwired.
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              busy
);

    logic [1:0]        req_s;
    logic [1:0]        grant_s;
    logic              run_s;
    logic              xfer_s;
    logic              xfer_idx_s;
    logic [ADDR_W-1:0] xfer_addr_s;
    logic [DATA_W-1:0] xfer_data_s;

    logic              last_grant_r;
    logic              reg_write_r;
    logic [ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0] write_data_r;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    arb_state_e        state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              busy_r;
`endif

    // Request vector into the round-robin core.
    always_comb begin
        req_s = {wb1_valid, wb0_valid};
    end

    rr_arbiter2 u_rr_arbiter2 (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    // Grants are only honoured once the clear sweep has finished.
    always_comb begin
        if (state_r == ST_RUN) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
    end
`else
    // Without the clear sweep the arbiter is always running.
    always_comb begin
        run_s = 1'b1;
    end
`endif

    // Ready is suppressed during reset so no transfer is seen at a reset edge.
    always_comb begin
        if (run_s && !rst) begin
            wb0_ready = grant_s[0];
            wb1_ready = grant_s[1];
        end else begin
            wb0_ready = 1'b0;
            wb1_ready = 1'b0;
        end
    end

    // Select the winning requester's payload.
    always_comb begin
        xfer_s     = (wb0_valid && wb0_ready) || (wb1_valid && wb1_ready);
        xfer_idx_s = grant_index({wb1_ready, wb0_ready});
        if (xfer_idx_s == REQ_LOAD) begin
            xfer_addr_s = wb1_addr;
            xfer_data_s = wb1_data;
        end else begin
            xfer_addr_s = wb0_addr;
            xfer_data_s = wb0_data;
        end
    end

    // Registered write port, last-grant pointer and optional clear sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
            // Pointing at requester 1 makes requester 0 win the first tie.
            last_grant_r <= REQ_LOAD;
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= {ADDR_W{1'b0}};
            busy_r       <= 1'b1;
`endif
        end
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
        else if (state_r == ST_CLEAR) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= clr_cnt_r;
            write_data_r <= {DATA_W{1'b0}};
            clr_cnt_r    <= clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                state_r <= ST_RUN;
                busy_r  <= 1'b0;
            end else begin
                state_r <= ST_CLEAR;
                busy_r  <= 1'b1;
            end
        end
`endif
        else if (xfer_s) begin
            // Register 0 is hardwired: accept the transfer, drop the write.
            reg_write_r  <= (xfer_addr_s != {ADDR_W{1'b0}});
            write_reg_r  <= xfer_addr_s;
            write_data_r <= xfer_data_s;
            last_grant_r <= xfer_idx_s;
        end else begin
            reg_write_r  <= 1'b0;
        end
    end

    assign RegWrite   = reg_write_r;
    assign write_reg  = write_reg_r;
    assign write_data = write_data_r;

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    assign busy = busy_r;
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb0_valid;
    logic [2:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [2:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        RegWrite;
    logic [2:0]  write_reg;
    logic [31:0] write_data;
    logic        busy;

    int checks;
    int failures;

    // Behavioural register file fed by the DUT write port.
    logic [31:0] regs [8];

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb0_valid  (wb0_valid),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb0_ready  (wb0_ready),
        .wb1_valid  (wb1_valid),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .wb1_ready  (wb1_ready),
        .RegWrite   (RegWrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RegWrite === 1'b1) regs[write_reg] <= write_data;
    end

    task automatic do_reset();
        rst = 1'b1;
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_wait busy=%b required 0", busy);
            end
            @(posedge clk);
            @(negedge clk);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb0_valid = 1'b1; wb0_addr = 3'd1; wb0_data = 32'h1;
        wb1_valid = 1'b1; wb1_addr = 3'd2; wb1_data = 32'h2;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b%b required 00", wb1_ready, wb0_ready);
        end
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_regwrite got %b required 0", RegWrite);
        end
        checks++;
        if (write_reg !== 3'd0) begin
            failures++;
            $display("FAIL reset_write_reg got %0d required 0", write_reg);
        end
        checks++;
        if (write_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_write_data got %h required 0", write_data);
        end
        checks++;
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy got %b required 1", busy);
        end
`else
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b required 0", busy);
        end
`endif
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 3'd3; wb0_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_ready got %b%b required 01", wb1_ready, wb0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb0_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd3 || write_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_out got we=%b reg=%0d data=%h required 1/3/deadbeef",
                     RegWrite, write_reg, write_data);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (regs[3] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_commit got %h required deadbeef", regs[3]);
        end
        checks++;
        if (RegWrite !== 1'b0 || write_reg !== 3'd3 || write_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_idle_hold got we=%b reg=%0d data=%h required 0/3/deadbeef",
                     RegWrite, write_reg, write_data);
        end
    endtask

    task automatic test_tie();
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 3'd1; wb0_data = 32'h11;
        wb1_valid = 1'b1; wb1_addr = 3'd2; wb1_data = 32'h22;
        for (int i = 0; i < 6; i++) begin
            logic exp1;
            exp1 = (i % 2 == 1);
            #1;
            checks++;
            if (wb0_ready !== !exp1 || wb1_ready !== exp1) begin
                failures++;
                $display("FAIL tie_grant[%0d] got %b%b required %b%b",
                         i, wb1_ready, wb0_ready, exp1, !exp1);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (RegWrite !== 1'b1 || write_reg !== (exp1 ? 3'd2 : 3'd1) ||
                write_data !== (exp1 ? 32'h22 : 32'h11)) begin
                failures++;
                $display("FAIL tie_out[%0d] got we=%b reg=%0d data=%h", i, RegWrite, write_reg, write_data);
            end
        end
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

    task automatic test_same_addr();
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 3'd5; wb0_data = 32'hA;
        wb1_valid = 1'b1; wb1_addr = 3'd5; wb1_data = 32'hB;
        #1;
        checks++;
        if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
            failures++;
            $display("FAIL same_first_grant got %b%b required 01", wb1_ready, wb0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb0_valid = 1'b0;
        #1;
        checks++;
        if (wb1_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_second_grant got %b required 1", wb1_ready);
        end
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd5 || write_data !== 32'hA) begin
            failures++;
            $display("FAIL same_out_a got we=%b reg=%0d data=%h", RegWrite, write_reg, write_data);
        end
        @(posedge clk);
        @(negedge clk);
        wb1_valid = 1'b0;
        checks++;
        if (regs[5] !== 32'hA || write_data !== 32'hB) begin
            failures++;
            $display("FAIL same_mid got reg5=%h data=%h required a/b", regs[5], write_data);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (regs[5] !== 32'hB) begin
            failures++;
            $display("FAIL same_final got %h required b", regs[5]);
        end
    endtask

    task automatic test_addr0();
        logic [31:0] saved;
        do_reset();
        saved = regs[0];
        wb1_valid = 1'b1; wb1_addr = 3'd0; wb1_data = 32'hFFFFFFFF;
        #1;
        checks++;
        if (wb1_ready !== 1'b1) begin
            failures++;
            $display("FAIL addr0_ready got %b required 1", wb1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        wb1_valid = 1'b0;
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL addr0_regwrite got %b required 0", RegWrite);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (regs[0] !== saved) begin
            failures++;
            $display("FAIL addr0_reg got %h required %h", regs[0], saved);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 3'd6; wb0_data = 32'h66;
        @(posedge clk);
        @(negedge clk);
        wb0_valid = 1'b0;
        rst = 1'b1;
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd6) begin
            failures++;
            $display("FAIL midrst_pre got we=%b reg=%0d required 1/6", RegWrite, write_reg);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL midrst_regwrite got %b required 0", RegWrite);
        end
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
        begin
            int n;
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
`endif
        wb0_valid = 1'b1; wb0_addr = 3'd1; wb0_data = 32'h1;
        wb1_valid = 1'b1; wb1_addr = 3'd2; wb1_data = 32'h2;
        #1;
        checks++;
        if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_tiebreak got %b%b required 01", wb1_ready, wb0_ready);
        end
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
    endtask

`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
    task automatic test_clear();
        int n;
        do_reset();
        for (int i = 1; i < 8; i++) begin
            wb0_valid = 1'b1; wb0_addr = i[2:0]; wb0_data = 32'h100 + i;
            @(posedge clk);
            @(negedge clk);
        end
        wb0_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (regs[7] !== 32'h107) begin
            failures++;
            $display("FAIL clear_preload got %h required 107", regs[7]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        wb0_valid = 1'b1; wb0_addr = 3'd1; wb0_data = 32'h55;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            #1;
            checks++;
            if (wb0_ready !== 1'b0) begin
                failures++;
                $display("FAIL clear_ready_low got %b required 0", wb0_ready);
            end
            @(negedge clk);
            n++;
        end
        wb0_valid = 1'b0;
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL clear_busy_cycles got %0d required 8", n);
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (regs[i] !== 32'h0) begin
                failures++;
                $display("FAIL clear_reg[%0d] got %h required 0", i, regs[i]);
            end
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (write_reg !== 3'd3) begin
            failures++;
            $display("FAIL clear_progress got %0d required 3", write_reg);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (RegWrite !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_restart_rst got we=%b busy=%b required 0/1", RegWrite, busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (RegWrite !== 1'b1 || write_reg !== 3'd0) begin
            failures++;
            $display("FAIL clear_restart_addr got we=%b reg=%0d required 1/0", RegWrite, write_reg);
        end
        do_reset();
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        wb0_valid = 1'b0; wb0_addr = 3'd0; wb0_data = 32'h0;
        wb1_valid = 1'b0; wb1_addr = 3'd0; wb1_data = 32'h0;
        @(negedge clk);
        test_reset();
        test_single();
        test_tie();
        test_same_addr();
        test_addr0();
        test_mid_reset();
`ifdef REGFILE_WRITE_ARBITER_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
